sqnorm_dot_engine: RTL and testbench

//  Parametrised successor of the fixed 1000x27-bit sum-of-squares engine. Streams one element per

---
 rtl/sqnorm_pkg.sv | 11 +
 rtl/sqnorm_sync_ram.sv | 27 ++
 rtl/sqnorm_dot_engine.sv | 172 +++++++++++++++++
 tb/tb_sqnorm_dot_engine.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sqnorm_pkg.sv
// Shared types and constants for the sum-of-squares / dot-product engine.
package sqnorm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  typedef enum logic {MODE_SQ = 1'b0, MODE_DOT = 1'b1} mode_e;

  // Valid stages: issue (combinational), read data, registered product.
  localparam int unsigned PIPE_STAGES = 3;

endpackage

// File: rtl/sqnorm_sync_ram.sv
// Single-port array with registered read data; contents are never reset.
module sqnorm_sync_ram #(
  parameter int unsigned DATA_W = 27,
  parameter int unsigned DEPTH  = 1000,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/sqnorm_dot_engine.sv
// Streams a[i]*a[i] or a[i]*b[i] from two on-chip arrays into a wrapping signed accumulator,
// with a host port that can steal the arrays and stall issue.
module sqnorm_dot_engine
  import sqnorm_pkg::*;
#(
  parameter int unsigned DATA_W = 27,
  parameter int unsigned DEPTH  = 1000,
  parameter int unsigned ACC_W  = 64,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r_enable,
  input  logic              mode,
  input  logic [ADDR_W-1:0] init_i,
  input  logic [ACC_W-1:0]  init_acc,
  input  logic              ctrl_arr,
  input  logic              ctrl_sel,
  input  logic              ctrl_we,
  input  logic [ADDR_W-1:0] ctrl_addr,
  input  logic [DATA_W-1:0] ctrl_wdata,
  output logic [DATA_W-1:0] ctrl_rdata,
  output logic              busy,
  output logic              w_enable,
  output logic [ACC_W-1:0]  result,
  output logic              overflow
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  if (ACC_W < PROD_W) begin : g_acc_w_check
    $error("ACC_W must be at least 2*DATA_W");
  end
  if (DEPTH < 2) begin : g_depth_check
    $error("DEPTH must be at least 2");
  end

  state_e state_q, state_d;
  mode_e  mode_q;
  logic [ADDR_W-1:0] idx_q;
  logic [PIPE_STAGES-1:0] vld;
  logic [PIPE_STAGES-1:1] vld_q;
  logic issue, init_oob;

  logic [DATA_W-1:0] a_rd, b_rd;
  logic signed [DATA_W-1:0] a_s, b_s, mul_b;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0] prod_ext, acc_q, sum;
  logic [ACC_W-1:0] result_q;
  logic w_enable_q, overflow_q;
  logic host_rd_q, host_sel_q;
  logic [DATA_W-1:0] host_hold_q;

  assign init_oob = 32'(init_i) >= DEPTH;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      RUN: begin
        if (!ctrl_arr) begin
          issue = 1'b1;
          if (idx_q == LAST_IDX) state_d = DRAIN;
        end
      end
      DRAIN: if (vld == '0) state_d = DONE;
      default: ;
    endcase
    // A start pulse wins in every state and discards whatever is in flight.
    if (r_enable) begin
      issue   = 1'b0;
      state_d = init_oob ? DONE : RUN;
    end
  end

  assign vld = {vld_q, issue};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  sqnorm_sync_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram_a (
    .clk     (clk),
    .en_i    (issue | (ctrl_arr & ~ctrl_sel)),
    .we_i    (ctrl_arr & ~ctrl_sel & ctrl_we),
    .addr_i  (ctrl_arr ? ctrl_addr : idx_q),
    .wdata_i (ctrl_wdata),
    .rdata_o (a_rd)
  );

  sqnorm_sync_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram_b (
    .clk     (clk),
    .en_i    (issue | (ctrl_arr & ctrl_sel)),
    .we_i    (ctrl_arr & ctrl_sel & ctrl_we),
    .addr_i  (ctrl_arr ? ctrl_addr : idx_q),
    .wdata_i (ctrl_wdata),
    .rdata_o (b_rd)
  );

  assign a_s      = a_rd;
  assign b_s      = b_rd;
  assign mul_b    = (mode_q == MODE_DOT) ? b_s : a_s;
  assign prod_ext = ACC_W'(prod_q);
  assign sum      = acc_q + prod_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_SQ;
      idx_q      <= '0;
      vld_q      <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      w_enable_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (r_enable) begin
      mode_q     <= mode_e'(mode);
      idx_q      <= init_i;
      vld_q      <= '0;
      acc_q      <= init_acc;
      overflow_q <= 1'b0;
      w_enable_q <= init_oob;
      if (init_oob) result_q <= init_acc;
    end else begin
      vld_q <= vld[PIPE_STAGES-2:0];
      if (issue) idx_q <= idx_q + ADDR_W'(1);
      if (vld_q[1]) prod_q <= PROD_W'(a_s) * PROD_W'(mul_b);
      if (vld_q[PIPE_STAGES-1]) begin
        acc_q <= sum;
        if ((acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1])) begin
          overflow_q <= 1'b1;
        end
      end
      if ((state_q == DRAIN) && (vld == '0)) begin
        result_q   <= acc_q;
        w_enable_q <= 1'b1;
      end
    end
  end

  // Host read data is valid only the cycle after a host read; otherwise the last value is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rd_q   <= 1'b0;
      host_sel_q  <= 1'b0;
      host_hold_q <= '0;
    end else begin
      host_rd_q   <= ctrl_arr & ~ctrl_we;
      host_sel_q  <= ctrl_sel;
      host_hold_q <= ctrl_rdata;
    end
  end

  always_comb begin
    ctrl_rdata = host_hold_q;
    if (host_rd_q) ctrl_rdata = host_sel_q ? b_rd : a_rd;
  end

  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign w_enable = w_enable_q;
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sqnorm_dot_engine.sv
// Directed bench: a 64-bit DEPTH=8 engine and a 16-bit DEPTH=6 engine share all inputs;
// the second covers accumulator wrap and init_i>=DEPTH, which a 3-bit index cannot reach at 8.
module tb_sqnorm_dot_engine;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 3;

  typedef struct {
    logic [63:0] res;
    logic        ovf;
    int          lat;
    logic        busy;
    string       tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          r_enable, mode;
  logic [AW-1:0] init_i;
  logic [63:0]   init_acc;
  logic          ctrl_arr, ctrl_sel, ctrl_we;
  logic [AW-1:0] ctrl_addr;
  logic [DW-1:0] ctrl_wdata;

  logic [DW-1:0] rdata_w, rdata_n;
  logic          busy_w, busy_n, wen_w, wen_n, ovf_w, ovf_n;
  logic [63:0]   result_w;
  logic [15:0]   result_n;

  exp_t        sb[$];
  logic [DW-1:0] b_model [8];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  sqnorm_dot_engine #(.DATA_W(DW), .DEPTH(8), .ACC_W(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .mode(mode), .init_i(init_i),
    .init_acc(init_acc), .ctrl_arr(ctrl_arr), .ctrl_sel(ctrl_sel), .ctrl_we(ctrl_we),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_rdata(rdata_w), .busy(busy_w),
    .w_enable(wen_w), .result(result_w), .overflow(ovf_w)
  );

  sqnorm_dot_engine #(.DATA_W(DW), .DEPTH(6), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .r_enable(r_enable), .mode(mode), .init_i(init_i),
    .init_acc(init_acc[15:0]), .ctrl_arr(ctrl_arr), .ctrl_sel(ctrl_sel), .ctrl_we(ctrl_we),
    .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_rdata(rdata_n), .busy(busy_n),
    .w_enable(wen_n), .result(result_n), .overflow(ovf_n)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input logic sel, input logic [AW-1:0] addr, input logic [DW-1:0] d);
    ctrl_arr   = 1'b1;
    ctrl_sel   = sel;
    ctrl_we    = 1'b1;
    ctrl_addr  = addr;
    ctrl_wdata = d;
    tick();
    ctrl_arr = 1'b0;
    ctrl_we  = 1'b0;
  endtask

  task automatic pulse(input logic m, input logic [AW-1:0] ii, input logic [63:0] seed);
    r_enable = 1'b1;
    mode     = m;
    init_i   = ii;
    init_acc = seed;
    tick();
    r_enable = 1'b0;
  endtask

  task automatic start_job(input logic m, input logic [AW-1:0] ii, input logic [63:0] seed,
                           input logic [63:0] res, input logic ovf, input int lat,
                           input logic bsy, input string tag);
    exp_t e;
    e.res  = res;
    e.ovf  = ovf;
    e.lat  = lat;
    e.busy = bsy;
    e.tag  = tag;
    sb.push_back(e);
    pulse(m, ii, seed);
  endtask

  // Called in cycle 1 after the start pulse; optional 3-cycle host read of b[2] from stall_at.
  task automatic wait_done(input bit inst, input int stall_at);
    exp_t e;
    int   cyc = 1;
    bit   seen = 1'b0;
    bit   saw_busy = 1'b0;
    e = sb.pop_front();
    while (!seen && cyc <= 100) begin
      if (inst ? busy_n : busy_w) saw_busy = 1'b1;
      if (inst ? wen_n : wen_w) begin
        seen = 1'b1;
      end else begin
        if (stall_at > 0) begin
          if (cyc == stall_at + 1) check({e.tag, "_host_rdata"}, 64'(rdata_w), 64'(b_model[2]));
          ctrl_arr  = (cyc >= stall_at) && (cyc < stall_at + 3);
          ctrl_sel  = 1'b1;
          ctrl_we   = 1'b0;
          ctrl_addr = 3'd2;
        end
        tick();
        cyc++;
      end
    end
    ctrl_arr = 1'b0;
    check({e.tag, "_done"}, 64'(seen), 64'd1);
    check({e.tag, "_result"}, inst ? 64'(result_n) : result_w, e.res);
    check({e.tag, "_overflow"}, 64'(inst ? ovf_n : ovf_w), 64'(e.ovf));
    check({e.tag, "_latency"}, 64'(cyc), 64'(e.lat));
    check({e.tag, "_busy_seen"}, 64'(saw_busy), 64'(e.busy));
  endtask

  initial begin
    rst_n = 1'b0; r_enable = 1'b0; mode = 1'b0; init_i = '0; init_acc = '0;
    ctrl_arr = 1'b0; ctrl_sel = 1'b0; ctrl_we = 1'b0; ctrl_addr = '0; ctrl_wdata = '0;
    tick();
    tick();
    check("rst_busy", 64'(busy_w), 64'd0);
    check("rst_w_enable", 64'(wen_w), 64'd0);
    check("rst_result", result_w, 64'd0);
    check("rst_overflow", 64'(ovf_w), 64'd0);
    check("rst_ctrl_rdata", 64'(rdata_w), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      host_write(1'b0, AW'(i), DW'(i + 1));
      b_model[i] = 8'hFE;
      host_write(1'b1, AW'(i), b_model[i]);
    end

    // 1^2 + ... + 8^2
    start_job(1'b0, 3'd0, 64'd0, 64'd204, 1'b0, 12, 1'b1, "sq");
    wait_done(1'b0, 0);
    // 100 - 2*(6+7+8)
    start_job(1'b1, 3'd5, 64'd100, 64'd58, 1'b0, 7, 1'b1, "dot");
    wait_done(1'b0, 0);
    // 10 - 2*36 with a 3-cycle host stall mid-run
    start_job(1'b1, 3'd0, 64'd10, -64'sd62, 1'b0, 15, 1'b1, "stall");
    wait_done(1'b0, 3);

    // Reset lands in DRAIN (cycles 9..11 of a full run).
    pulse(1'b0, 3'd0, 64'd0);
    repeat (9) tick();
    check("drain_busy_before_rst", 64'(busy_w), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy_w), 64'd0);
    check("midrst_w_enable", 64'(wen_w), 64'd0);
    check("midrst_result", result_w, 64'd0);
    check("midrst_overflow", 64'(ovf_w), 64'd0);
    check("midrst_ctrl_rdata", 64'(rdata_w), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start_job(1'b0, 3'd0, 64'd0, 64'd204, 1'b0, 12, 1'b1, "rerun");
    wait_done(1'b0, 0);

    for (int i = 0; i < 6; i++) host_write(1'b0, AW'(i), 8'h80);
    // 32767 + 6*16384 wraps to 0xFFFF in 16 bits
    start_job(1'b0, 3'd0, 64'd32767, 64'h0000_0000_0000_FFFF, 1'b1, 10, 1'b1, "wrap16");
    wait_done(1'b1, 0);
    start_job(1'b0, 3'd5, 64'd0, 64'h0000_0000_0000_4000, 1'b0, 5, 1'b1, "clear16");
    check("clear16_ovf_at_start", 64'(ovf_n), 64'd0);
    wait_done(1'b1, 0);
    start_job(1'b0, 3'd6, -64'sd7, 64'h0000_0000_0000_FFF9, 1'b0, 1, 1'b0, "oob16");
    wait_done(1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
